// File: rtl/rr_arb8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb8
//  Purpose  : 8-way round-robin arbiter with per-grant hold limit and a
//             timeout pulse on forced release. Define RR_ARB8_PRIO0_EN to give
//             requester 0 absolute priority when a new grant is chosen.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam bit         C_HOLD_EN   = (HOLD_MAX != 0);

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [7:0] cnt_q;
    logic [7:0] gnt_q;
    logic [2:0] idx_q;
    logic       vld_q;
    logic       timeout_q;

    logic [2:0] w_win_idx;
    logic       w_any_req;
    logic       w_vol_rel;
    logic       w_lim_rel;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin : p_search
        w_win_idx = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr_q + 3'(k)]) begin
                w_win_idx = ptr_q + 3'(k);
            end
        end
`ifdef RR_ARB8_PRIO0_EN
        if (req[0]) begin
            w_win_idx = 3'd0;
        end
`endif
    end

    assign w_any_req = |req;
    assign w_vol_rel = done | ~req[idx_q];
    assign w_lim_rel = C_HOLD_EN && (cnt_q == C_HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin : p_fsm
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
            gnt_q     <= 8'h00;
            idx_q     <= 3'd0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        state_q <= S_GRANT;
                        gnt_q   <= 8'b1 << w_win_idx;
                        idx_q   <= w_win_idx;
                        vld_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (w_vol_rel || w_lim_rel) begin
                        state_q   <= S_IDLE;
                        gnt_q     <= 8'h00;
                        idx_q     <= 3'd0;
                        vld_q     <= 1'b0;
                        ptr_q     <= idx_q + 3'd1;
                        // A voluntary release on the limit cycle is not a timeout.
                        timeout_q <= w_lim_rel & ~w_vol_rel;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15: maximum GRANT cycles per grant; 0 = unlimited; legal range 0..255.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 SHALL have port done  input  1  current holder finished; meaningful only while gnt_vld=1.
REQ-006 SHALL have port gnt  output  8  one-hot grant, all-zero when idle; drives resource select directly.
REQ-007 SHALL have port gnt_idx  output  3  binary index of granted requester; 0 when idle.
REQ-008 SHALL have port gnt_vld  output  1  grant active.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse on forced release by HOLD_MAX.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, GRANT; all outputs registered.
REQ-011 SHALL keep a 3-bit pointer ptr; in IDLE the winner is the first i with req[i]=1, searching ptr, ptr+1, ... modulo 8.
REQ-012 SHALL, in IDLE with req!=0 at edge N, enter GRANT so that gnt/gnt_idx/gnt_vld are valid after edge N (1-cycle latency).
REQ-013 SHALL stay in IDLE with all outputs zero when req==0.
REQ-014 SHALL hold gnt, gnt_idx and gnt_vld constant throughout GRANT regardless of other req bits.
REQ-015 SHALL release (GRANT->IDLE) at the edge where any holds: done=1; req[gnt_idx]=0; hold counter = HOLD_MAX-1 with HOLD_MAX!=0.
REQ-016 SHALL, on release, set ptr = gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-017 SHALL spend at least one IDLE cycle between grants; a new grant is visible no earlier than two edges after the releasing edge.
REQ-018 SHALL count GRANT cycles in an 8-bit counter cleared on entry to GRANT; no wrap is possible because HOLD_MAX<=255.
REQ-019 SHALL assert timeout for exactly the cycle after a HOLD_MAX release, and SHALL NOT assert it if done or req-drop coincides with the limit (voluntary release wins).
REQ-020 SHALL keep gnt one-hot and consistent with gnt_idx whenever gnt_vld=1.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force state=IDLE, ptr=0, counter=0, gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0.
REQ-022 SHALL drop an active grant immediately on mid-grant reset, with no timeout pulse.
REQ-023 SHALL resume arbitration from ptr=0 at the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro RR_ARB8_PRIO0_EN defined, grant requester 0 in IDLE whenever req[0]=1, ignoring ptr; release and ptr update are unchanged.
REQ-025 SHALL, without RR_ARB8_PRIO0_EN, apply pure round-robin to all eight requesters.

Verification
REQ-026 SHALL cover: reset, req=8'h00 for 10 cycles -> gnt=0, gnt_vld=0, timeout=0 throughout.
REQ-027 SHALL cover: req=8'hFF held, done pulsed one cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-028 SHALL cover: ptr=6 after granting 5, req=8'h21 -> gnt_idx=0 (wrap past 7); without prio macro, req=8'h41 with ptr=1 -> gnt_idx=6.
REQ-029 SHALL cover: HOLD_MAX=4, req=8'h08 held, done=0 -> gnt=8'h08 for 4 cycles, then timeout=1 one cycle, then re-grant of 3.
REQ-030 SHALL cover: rst_n pulled low mid-grant, asynchronously to clk -> gnt=0 before the next clk edge; after release, req=8'h80 -> gnt_idx=7 after one edge.
REQ-031 SHALL cover: RR_ARB8_PRIO0_EN defined, ptr=3, req=8'h09 -> gnt_idx=0; same stimulus without macro -> gnt_idx=3.
